// File: rtl/regfile_wr_arb_if.sv
// Handshake/bus bundle between writeback requesters, the write-port arbiter and the register file.
interface regfile_wr_arb_if #(
  parameter int unsigned pw   = 3,
  parameter int unsigned NREQ = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*pw-1:0] req_addr;
  logic [NREQ*8-1:0]  req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wr_en;
  logic [pw-1:0]      wr_addr;
  logic [7:0]         wr_data;
  logic [1:0]         grant_id;
  logic               init_busy;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_en, wr_addr, wr_data, grant_id, init_busy
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_en, wr_addr, wr_data, grant_id, init_busy
  );
endinterface

// File: rtl/regfile_wr_arb.sv
// Round-robin write-port arbiter for the 8-bit register file.
// Define REGFILE_INIT_EN to compile in the post-reset zero-fill sweep.
module regfile_wr_arb #(
  parameter int unsigned pw   = 3,
  parameter int unsigned NREQ = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  regfile_wr_arb_if.slave io_bus
);

  logic            r_wr_en, w_wr_en_d;
  logic [pw-1:0]   r_wr_addr, w_wr_addr_d;
  logic [7:0]      r_wr_data, w_wr_data_d;
  logic [1:0]      r_grant_id, w_grant_id_d;
  logic [1:0]      r_rr_ptr, w_rr_ptr_d;

  logic            w_run;
  logic            w_found_hi, w_found_lo;
  logic [1:0]      w_win_hi, w_win_lo, w_winner;
  logic [NREQ-1:0] w_ready;
  logic            w_xfer;
  logic [pw-1:0]   w_sel_addr;
  logic [7:0]      w_sel_data;

`ifdef REGFILE_INIT_EN
  typedef enum logic [0:0] {StInit, StRun} state_e;
  state_e        r_state, w_state_d;
  logic [pw-1:0] r_cnt, w_cnt_d;

  assign w_run            = (r_state == StRun);
  assign io_bus.init_busy = (r_state == StInit);
`else
  assign w_run            = 1'b1;
  assign io_bus.init_busy = 1'b0;
`endif

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_win_hi   = 2'd0;
    w_win_lo   = 2'd0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (io_bus.req_valid[i]) begin
        w_found_lo = 1'b1;
        w_win_lo   = 2'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_found_hi = 1'b1;
          w_win_hi   = 2'(i);
        end
      end
    end
    w_winner = w_found_hi ? w_win_hi : w_win_lo;
  end

  always_comb begin
    w_ready    = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_winner == 2'(i)) begin
        w_ready[i] = w_found_lo && w_run && i_rst_n;
        w_sel_addr = io_bus.req_addr[i*pw +: pw];
        w_sel_data = io_bus.req_data[i*8 +: 8];
      end
    end
  end

  assign w_xfer = |w_ready;

  always_comb begin
    w_wr_en_d    = w_xfer;
    w_wr_addr_d  = r_wr_addr;
    w_wr_data_d  = r_wr_data;
    w_grant_id_d = r_grant_id;
    w_rr_ptr_d   = r_rr_ptr;
    if (w_xfer) begin
      w_wr_addr_d  = w_sel_addr;
      w_wr_data_d  = w_sel_data;
      w_grant_id_d = w_winner;
      w_rr_ptr_d   = (w_winner == 2'(NREQ - 1)) ? 2'd0 : w_winner + 2'd1;
    end
`ifdef REGFILE_INIT_EN
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      StInit: begin
        w_wr_en_d   = 1'b1;
        w_wr_addr_d = r_cnt;
        w_wr_data_d = 8'h00;
        w_cnt_d     = r_cnt + 1'b1;
        if (r_cnt == {pw{1'b1}}) w_state_d = StRun;
      end
      default: w_state_d = StRun;
    endcase
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
      r_grant_id <= 2'd0;
      r_rr_ptr   <= 2'd0;
`ifdef REGFILE_INIT_EN
      r_state    <= StInit;
      r_cnt      <= '0;
`endif
    end else begin
      r_wr_en    <= w_wr_en_d;
      r_wr_addr  <= w_wr_addr_d;
      r_wr_data  <= w_wr_data_d;
      r_grant_id <= w_grant_id_d;
      r_rr_ptr   <= w_rr_ptr_d;
`ifdef REGFILE_INIT_EN
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
`endif
    end
  end

  assign io_bus.req_ready = w_ready;
  assign io_bus.wr_en     = r_wr_en;
  assign io_bus.wr_addr   = r_wr_addr;
  assign io_bus.wr_data   = r_wr_data;
  assign io_bus.grant_id  = r_grant_id;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb with a behavioural register file on the write port.
module tb_regfile_wr_arb;
  localparam int unsigned PW   = 3;
  localparam int unsigned NREQ = 3;
`ifdef REGFILE_INIT_EN
  localparam bit INIT_ON = 1'b1;
`else
  localparam bit INIT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  logic [7:0] mem [8];

  always #5 clk = ~clk;

  regfile_wr_arb_if #(.pw(PW), .NREQ(NREQ)) bus ();

  regfile_wr_arb #(.pw(PW), .NREQ(NREQ)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  // Register file: write is dropped on a reset edge.
  always @(posedge clk) if (rst_n && bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] a, input logic [7:0] d);
    bus.req_valid[i]       = v;
    bus.req_addr[i*3 +: 3] = a;
    bus.req_data[i*8 +: 8] = d;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if (INIT_ON) repeat (8) tick();
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    rst_n = 1'b0;
    tick();
    tick();
    n_run++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
    n_run++; if (bus.wr_addr !== 3'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); end
    n_run++; if (bus.wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", bus.wr_data); end
    n_run++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", bus.grant_id); end
    n_run++; if (bus.init_busy !== INIT_ON) begin n_fail++; $display("FAIL reset_init_busy: got %b want %b", bus.init_busy, INIT_ON); end
    rst_n = 1'b1;
    if (INIT_ON) repeat (8) tick();
  endtask

`ifdef REGFILE_INIT_EN
  task automatic test_sweep();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 3'(i), 8'hE0 + 8'(i));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_run++; if (bus.init_busy !== 1'b1) begin n_fail++; $display("FAIL sweep_busy_start: got %b want 1", bus.init_busy); end
    n_run++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL sweep_ready_start: got %b want 000", bus.req_ready); end
    for (int k = 0; k < 8; k++) begin
      tick();
      n_run++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'(k) || bus.wr_data !== 8'h00) begin
        n_fail++; $display("FAIL sweep_write%0d: got en=%b addr=%0d data=%h want en=1 addr=%0d data=00", k, bus.wr_en, bus.wr_addr, bus.wr_data, k);
      end
      n_run++; if (bus.init_busy !== (k < 7)) begin n_fail++; $display("FAIL sweep_busy%0d: got %b want %b", k, bus.init_busy, (k < 7)); end
      n_run++; if (bus.req_ready !== ((k < 7) ? 3'b000 : 3'b001)) begin
        n_fail++; $display("FAIL sweep_ready%0d: got %b want %b", k, bus.req_ready, (k < 7) ? 3'b000 : 3'b001);
      end
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_sweep_restart();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    n_run++; if (bus.wr_addr !== 3'd4) begin n_fail++; $display("FAIL restart_pre_addr: got %0d want 4", bus.wr_addr); end
    rst_n = 1'b0;
    tick();
    n_run++; if (bus.wr_en !== 1'b0 || bus.init_busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_reset: got en=%b busy=%b want en=0 busy=1", bus.wr_en, bus.init_busy);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_run++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'(k)) begin
        n_fail++; $display("FAIL restart_write%0d: got en=%b addr=%0d want en=1 addr=%0d", k, bus.wr_en, bus.wr_addr, k);
      end
    end
    tick();
    n_run++; if (bus.wr_en !== 1'b0 || bus.init_busy !== 1'b0) begin
      n_fail++; $display("FAIL restart_end: got en=%b busy=%b want en=0 busy=0", bus.wr_en, bus.init_busy);
    end
  endtask
`endif

  task automatic test_single();
    do_reset();
    set_req(1, 1'b1, 3'd5, 8'hA5);
    #1;
    n_run++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready0: got %b want 010", bus.req_ready); end
    tick();
    n_run++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd5 || bus.wr_data !== 8'hA5 || bus.grant_id !== 2'd1) begin
      n_fail++; $display("FAIL single_wr0: got en=%b addr=%0d data=%h id=%0d want 1/5/a5/1", bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_id);
    end
    set_req(1, 1'b1, 3'd6, 8'h3C);
    #1;
    n_run++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready1: got %b want 010", bus.req_ready); end
    tick();
    n_run++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd6 || bus.wr_data !== 8'h3C || bus.grant_id !== 2'd1) begin
      n_fail++; $display("FAIL single_wr1: got en=%b addr=%0d data=%h id=%0d want 1/6/3c/1", bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_id);
    end
    set_req(1, 1'b0, 3'd0, 8'h00);
    #1;
    n_run++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL idle_ready: got %b want 000", bus.req_ready); end
    tick();
    n_run++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL idle_wr_en: got %b want 0", bus.wr_en); end
    n_run++; if (mem[5] !== 8'hA5) begin n_fail++; $display("FAIL single_mem5: got %h want a5", mem[5]); end
    n_run++; if (mem[6] !== 8'h3C) begin n_fail++; $display("FAIL single_mem6: got %h want 3c", mem[6]); end
  endtask

  task automatic test_round_robin();
    logic [2:0] oh;
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 3'(i), 8'h10 + 8'(i));
    for (int n = 0; n < 6; n++) begin
      oh = 3'b001 << (n % 3);
      #1;
      n_run++; if (bus.req_ready !== oh) begin n_fail++; $display("FAIL rr_ready%0d: got %b want %b", n, bus.req_ready, oh); end
      tick();
      n_run++; if (bus.grant_id !== 2'(n % 3) || bus.wr_addr !== 3'(n % 3) || bus.wr_en !== 1'b1) begin
        n_fail++; $display("FAIL rr_grant%0d: got id=%0d addr=%0d en=%b want id=%0d", n, bus.grant_id, bus.wr_addr, bus.wr_en, n % 3);
      end
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_same_addr();
    set_req(1, 1'b1, 3'd0, 8'h00);
    tick();
    set_req(1, 1'b0, 3'd0, 8'h00);
    set_req(0, 1'b1, 3'd3, 8'h11);
    set_req(2, 1'b1, 3'd3, 8'h22);
    #1;
    n_run++; if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL same_ready0: got %b want 100", bus.req_ready); end
    tick();
    n_run++; if (bus.grant_id !== 2'd2 || bus.wr_data !== 8'h22) begin
      n_fail++; $display("FAIL same_first: got id=%0d data=%h want id=2 data=22", bus.grant_id, bus.wr_data);
    end
    set_req(2, 1'b0, 3'd0, 8'h00);
    #1;
    n_run++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL same_ready1: got %b want 001", bus.req_ready); end
    tick();
    n_run++; if (bus.grant_id !== 2'd0 || bus.wr_data !== 8'h11 || bus.wr_addr !== 3'd3) begin
      n_fail++; $display("FAIL same_second: got id=%0d data=%h addr=%0d want 0/11/3", bus.grant_id, bus.wr_data, bus.wr_addr);
    end
    set_req(0, 1'b0, 3'd0, 8'h00);
    tick();
    tick();
    n_run++; if (mem[3] !== 8'h11) begin n_fail++; $display("FAIL same_mem3: got %h want 11", mem[3]); end
  endtask

  task automatic test_reset_drop();
    set_req(2, 1'b1, 3'd2, 8'h77);
    tick();
    set_req(2, 1'b0, 3'd0, 8'h00);
    tick();
    tick();
    set_req(2, 1'b1, 3'd2, 8'h99);
    tick();
    set_req(2, 1'b0, 3'd0, 8'h00);
    set_req(0, 1'b1, 3'd4, 8'h5A);
    rst_n = 1'b0;
    #1;
    n_run++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL drop_ready_in_reset: got %b want 000", bus.req_ready); end
    tick();
    n_run++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL drop_wr_en: got %b want 0", bus.wr_en); end
    n_run++; if (mem[2] !== 8'h77) begin n_fail++; $display("FAIL drop_mem2: got %h want 77", mem[2]); end
    rst_n = 1'b1;
    if (INIT_ON) repeat (8) tick();
    #1;
    n_run++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL drop_first_ready: got %b want 001", bus.req_ready); end
    tick();
    n_run++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd4 || bus.wr_data !== 8'h5A || bus.grant_id !== 2'd0) begin
      n_fail++; $display("FAIL drop_first_wr: got en=%b addr=%0d data=%h id=%0d want 1/4/5a/0", bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_id);
    end
    set_req(0, 1'b0, 3'd0, 8'h00);
    tick();
    tick();
    n_run++; if (mem[4] !== 8'h5A || mem[2] !== 8'h77) begin
      n_fail++; $display("FAIL drop_mem_final: got m4=%h m2=%h want 5a/77", mem[4], mem[2]);
    end
  endtask

  initial begin
    test_reset();
`ifdef REGFILE_INIT_EN
    test_sweep();
    test_sweep_restart();
`endif
    test_single();
    test_round_robin();
    test_same_addr();
    test_reset_drop();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
